// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional odd/even parity, one stop bit.
// The asynchronous line is double-flopped before use; all sampling is done
// mid-bit by counting clk cycles from the detected start edge.
//
// Output handshake: rx_done is a one-cycle strobe with no back-pressure.
// data_out, parity_err and frame_err update in the same cycle that rx_done
// is high, and they hold until the next strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LP_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5,
        S_BREAK  = 3'd6
    } state_t;

    logic          r_rx_meta;
    logic          r_rx_s;
    state_t        r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [1:0]    r_ptype;
    logic          r_par_err_next;
    logic [7:0]    r_data_out;
    logic          r_rx_done;
    logic          r_parity_err;
    logic          r_frame_err;

    logic          w_full;
    logic          w_has_parity;
    logic          w_exp_par;

    assign w_full       = (r_clk_cnt == LP_FULL);
    assign w_has_parity = (r_ptype == 2'b01) || (r_ptype == 2'b10);
    // Odd: the parity bit makes the total count of ones odd; even: makes it even.
    assign w_exp_par    = (r_ptype == 2'b01) ? ~^r_shift : ^r_shift;

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Receive FSM with its datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_clk_cnt      <= '0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_ptype        <= '0;
            r_par_err_next <= 1'b0;
            r_data_out     <= '0;
            r_rx_done      <= 1'b0;
            r_parity_err   <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        // Parity mode is frozen for the whole frame.
                        r_ptype        <= parity_type;
                        r_bit_cnt      <= '0;
                        r_clk_cnt      <= '0;
                        r_par_err_next <= 1'b0;
                        r_state        <= S_START;
                    end
                end
                S_START: begin
                    if (r_clk_cnt == LP_HALF) begin
                        r_clk_cnt <= '0;
                        // Line back high at mid start bit: a glitch, not a frame.
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_full) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= w_has_parity ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_full) begin
                        r_clk_cnt      <= '0;
                        r_par_err_next <= (r_rx_s != w_exp_par);
                        r_state        <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_full) begin
                        // Results land here so the strobe is visible during DONE.
                        r_clk_cnt    <= '0;
                        r_data_out   <= r_shift;
                        r_parity_err <= r_par_err_next;
                        r_frame_err  <= ~r_rx_s;
                        r_rx_done    <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // A low stop bit means the line may be held in break.
                    r_state <= r_frame_err ? S_BREAK : S_IDLE;
                end
                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign rx_done    = r_rx_done;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives ideal frames at CLKS_PER_BIT=16, predicts each
// received byte and its error flags into an expected queue, and compares
// them when rx_done strobes.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic [7:0] data_out;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [2:0] dbg_state;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .parity_type(parity_type),
        .data_out   (data_out),
        .rx_done    (rx_done),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [9:0] exp_q[$];  // {data[7:0], parity_err, frame_err}
    int         done_t[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       chk_busy = 1'b0;
    logic [9:0] e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every strobe; busy must drop one cycle later.
    always @(negedge clk) begin
        if (chk_busy) begin
            check_eq("busy_fall", 32'(busy), 32'd0);
            chk_busy = 1'b0;
        end
        if (rx_done) begin
            done_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", 32'(rx_done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("data_out",     32'(data_out),   32'(e[9:2]));
                check_eq("parity_err",   32'(parity_err), 32'(e[1]));
                check_eq("frame_err",    32'(frame_err),  32'(e[0]));
                check_eq("busy_at_done", 32'(busy),       32'd1);
                if (!e[0]) chk_busy = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Predict the result, then drive start, data LSB first, optional parity, stop.
    task automatic xfer(input logic [7:0] d, input logic par_bit, input logic stop);
        logic par_en;
        logic perr;
        int   ones;
        par_en = (parity_type == 2'b01) || (parity_type == 2'b10);
        ones   = $countones(d) + int'(par_bit);
        perr   = 1'b0;
        if (parity_type == 2'b01) perr = (ones % 2) == 0;
        if (parity_type == 2'b10) perr = (ones % 2) == 1;
        exp_q.push_back({d, perr, ~stop});
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_en) send_bit(par_bit);
        send_bit(stop);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d;
        repeat (3) @(negedge clk);
        check_eq("rst_data_out",   32'(data_out),   32'd0);
        check_eq("rst_rx_done",    32'(rx_done),    32'd0);
        check_eq("rst_parity_err", 32'(parity_err), 32'd0);
        check_eq("rst_frame_err",  32'(frame_err),  32'd0);
        check_eq("rst_busy",       32'(busy),       32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // No parity, good frame.
        parity_type = 2'b00;
        xfer(8'hA5, 1'b0, 1'b1);
        send_bit(1'b1);
        wait_drain("drain_nopar");

        // Even parity good/bad, then odd parity clears the flag.
        parity_type = 2'b10;
        xfer(8'h03, 1'b0, 1'b1);
        xfer(8'h03, 1'b1, 1'b1);
        parity_type = 2'b01;
        xfer(8'h00, 1'b1, 1'b1);
        send_bit(1'b1);
        wait_drain("drain_parity");

        // Short glitch: must not produce a frame or disturb outputs.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("glitch_busy_hi", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("glitch_busy_lo",    32'(busy),       32'd0);
        check_eq("glitch_data_out",   32'(data_out),   32'h00);
        check_eq("glitch_parity_err", 32'(parity_err), 32'd0);
        check_eq("glitch_frame_err",  32'(frame_err),  32'd0);
        repeat (20) @(negedge clk);

        // Frame error with line held low afterwards, then recovery.
        parity_type = 2'b00;
        xfer(8'h81, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("break_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("break_exit_busy", 32'(busy), 32'd0);
        wait_drain("drain_ferr");
        send_bit(1'b1);
        xfer(8'h5A, 1'b0, 1'b1);
        send_bit(1'b1);
        wait_drain("drain_recover");

        // Back-to-back frames with no idle time.
        parity_type = 2'b11;
        done_t.delete();
        xfer(8'h11, 1'b0, 1'b1);
        xfer(8'h22, 1'b0, 1'b1);
        xfer(8'h33, 1'b0, 1'b1);
        send_bit(1'b1);
        wait_drain("drain_b2b");
        check_eq("b2b_strobes", 32'(done_t.size()), 32'd3);
        if (done_t.size() == 3) begin
            d = done_t[1] - done_t[0];
            check_eq("b2b_gap1", 32'(d), 32'(10 * CPB));
            d = done_t[2] - done_t[1];
            check_eq("b2b_gap2", 32'(d), 32'(10 * CPB));
        end

        // Reset mid-frame after data bit 3.
        parity_type = 2'b00;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_data_out",   32'(data_out),   32'd0);
        check_eq("midrst_rx_done",    32'(rx_done),    32'd0);
        check_eq("midrst_parity_err", 32'(parity_err), 32'd0);
        check_eq("midrst_frame_err",  32'(frame_err),  32'd0);
        check_eq("midrst_busy",       32'(busy),       32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        xfer(8'hC3, 1'b0, 1'b1);
        send_bit(1'b1);
        wait_drain("drain_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive block for the UART link. It is the receive-side counterpart of the transmit path's parity generator. It samples an asynchronous `rx` line, recovers one 8-bit character framed as start, 8 data bits LSB first, optional parity and 1 stop bit, and checks parity with the same `parity_type` encoding the transmitter uses. It presents the byte plus error flags to the host logic with a single-cycle completion strobe.

## Interface
- `CLKS_PER_BIT`, default 868: `clk` cycles per bit period (868 gives 115200 baud at 100 MHz). Must be ≥ 4; the half-bit value is CLKS_PER_BIT/2 with integer division.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `parity_type`  in  2  encoding:
  - 2'b01 ODD
  - 2'b10 EVEN
  - 2'b00 / 2'b11 no parity bit in the frame
- `data_out`  out  8  last received byte.
- `rx_done`  out  1  one-cycle strobe; `data_out` and the error flags are valid and updated in the same cycle.
- `parity_err`  out  1  parity mismatch on the last frame; always 0 when no parity.
- `frame_err`  out  1  stop bit sampled low on the last frame.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Synchronizer: `rx` passes through 2 flops. Both reset to 1. All logic uses the synchronized `rx_s`.
- States:
  - IDLE: `rx_s`==0 → latch `parity_type` into `ptype_q`, clear bit counter, go to START. A `parity_type` change mid-frame has no effect.
  - START: at count CLKS_PER_BIT/2−1, sample `rx_s`.
    - 1 → false start: back to IDLE, no strobe, no flag change.
    - 0 → clear counter, go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample into the shift register, LSB first. After 8 samples, go to PARITY if `ptype_q` is 01/10, else go to STOP.
  - PARITY: sample after CLKS_PER_BIT. Expected bit:
    - ODD: ~^data
    - EVEN: ^data
    - `parity_err_next` = sampled ≠ expected.
  - STOP: sample after CLKS_PER_BIT. `frame_err_next` = (sample==0). Go to DONE.
  - DONE (1 cycle):
    - Register `data_out`, `parity_err`, `frame_err`; pulse `rx_done`.
    - Next state is IDLE if `frame_err_next`==0, else BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. This prevents a held-low line from being taken as a new start bit.
- The error flags hold their value until the next `rx_done`. They are overwritten, not accumulated.
- The byte is delivered even when `parity_err` or `frame_err` is set.

## Timing
- Reset values:
  - `data_out` = 8'h00
  - `rx_done` = `parity_err` = `frame_err` = `busy` = 0
  - state = IDLE, counters = 0
- Reset mid-frame aborts immediately: no `rx_done`, and all outputs go to their reset values.
- Let t0 be the first cycle in IDLE with `rx_s`==0. This is 2–3 cycles after the `rx` falling edge.
- Sample k is taken at t0 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT, where k = 0 is the start bit and k = 1..8 are the data bits.
  - Parity is sample 9, and stop is sample 9 or 10.
- `rx_done` is high in the cycle after the stop sample.
  - No parity: t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1.
- After `rx_done` with a good stop, the block is in IDLE about CLKS_PER_BIT/2 before the end of the stop bit. It therefore accepts back-to-back frames with zero idle time.
- Tolerance: correct reception with transmitter bit-period error of up to ±3%.

## Test plan
All scenarios use CLKS_PER_BIT=16 and drive ideal frames from the bench.
- No parity, `parity_type`=00, byte 0xA5, stop 1 → one `rx_done` pulse; `data_out`=A5; both flags 0; `busy` falls 1 cycle after the strobe.
- EVEN, 0x03 with parity 0 → `parity_err`=0. Then 0x03 with parity 1 → `data_out`=03, `parity_err`=1. Then ODD, 0x00 with parity 1 → `parity_err`=0, which confirms the flag is cleared.
- Glitch: `rx` low for 4 cycles then high → no `rx_done`; `busy` back to 0 by t0+8; outputs unchanged.
- Frame error: 0x81, no parity, stop 0, `rx` held low 40 more cycles then high → `frame_err`=1 with `data_out`=81; no second `rx_done` while low. Next frame 0x5A → `frame_err`=0, `data_out`=5A.
- Back-to-back: 0x11, 0x22, 0x33 with no idle gap, `parity_type`=11 → three strobes, spaced 10·16 cycles (±1), with correct bytes.
- Reset: assert `rst_n`=0 after data bit 3 of a frame → all outputs 0 asynchronously; no `rx_done`. After release plus idle, 0xC3 → received correctly.
